// File: rtl/dbus_sram_responder_pkg.sv
// Shared dbus payload types and the responder FSM state encoding.
package dbus_sram_responder_pkg;

  typedef enum logic [1:0] {
    MSIZE1,
    MSIZE2,
    MSIZE4
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dbus_resp_state_t;

endpackage

// File: rtl/dbus_ram.sv
// Byte-strobed 32-bit word RAM: synchronous write, synchronous registered read.
// Contents are deliberately never reset.
module dbus_ram #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] idx,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] mem [0:DEPTH-1];
  logic [31:0] rdata_q;

  // Byte-lane write and registered read on the accept edge
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata_q <= mem[idx];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dbus_sram_responder.sv
// dbus responder backed by an internal word RAM with programmable response latency.
// Optional feature macro: DBUS_RESP_LFSR_STALL_EN (LFSR-randomised grant and extra latency).
module dbus_sram_responder
  import dbus_sram_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 2,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic       clk,
  input  logic       resetn,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp
);

  // Wide enough for LATENCY-1 (max 14) plus up to 3 extra stall cycles
  localparam int unsigned CNT_W = 5;

  dbus_resp_state_t      state;
  logic [CNT_W-1:0]      cnt;
  logic                  is_wr_q;
  logic                  grant_ok;
  logic [1:0]            extra;
  logic                  accept;
  logic [CNT_W-1:0]      remaining;
  logic [ADDR_WIDTH-1:0] widx;
  logic [31:0]           rdata;

`ifdef DBUS_RESP_LFSR_STALL_EN
  logic [15:0] lfsr;

  // Free-running Fibonacci LFSR, taps 16,14,13,11
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr <= LFSR_SEED;
    else         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign grant_ok = lfsr[0];
  assign extra    = lfsr[2:1];

  logic unused_bits;
  assign unused_bits = ^{dreq.size, dreq.addr[31:ADDR_WIDTH+2], dreq.addr[1:0]};
`else
  assign grant_ok = 1'b1;
  assign extra    = 2'd0;

  logic unused_bits;
  assign unused_bits = ^{dreq.size, dreq.addr[31:ADDR_WIDTH+2], dreq.addr[1:0], LFSR_SEED};
`endif

  assign widx      = dreq.addr[ADDR_WIDTH+1:2];
  assign accept    = (state == IDLE) & dreq.valid & grant_ok;
  assign remaining = CNT_W'(LATENCY - 1) + CNT_W'(extra);

  dbus_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (accept & (|dreq.strobe)),
    .be   (dreq.strobe),
    .re   (accept & ~(|dreq.strobe)),
    .idx  (widx),
    .wdata(dreq.data),
    .rdata(rdata)
  );

  // Handshake FSM: accept, count down the latency, one-cycle response
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      cnt     <= '0;
      is_wr_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            is_wr_q <= |dreq.strobe;
            if (remaining == '0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= remaining;
            end
          end
        end
        WAIT: begin
          if (cnt == CNT_W'(1)) begin
            state <= RESP;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Response drive; addr_ok is forced low while reset is held
  always_comb begin
    dresp         = '0;
    dresp.addr_ok = accept & resetn;
    dresp.data_ok = (state == RESP);
    dresp.data    = ((state == RESP) && !is_wr_q) ? rdata : 32'h0;
  end

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Scoreboard bench for dbus_sram_responder (main instance LATENCY=2, side instance LATENCY=1).
module tb_dbus_sram_responder;
  import dbus_sram_responder_pkg::*;

  localparam int unsigned AW   = 10;
  localparam int unsigned LAT  = 2;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  dbus_req_t  dreq1;
  dbus_resp_t dresp1;

  always #5 clk = ~clk;

  dbus_sram_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT), .LFSR_SEED(SEED)) u_dut (
    .clk(clk), .resetn(resetn), .dreq(dreq), .dresp(dresp)
  );

  dbus_sram_responder #(.ADDR_WIDTH(AW), .LATENCY(1), .LFSR_SEED(SEED)) u_dut1 (
    .clk(clk), .resetn(resetn), .dreq(dreq1), .dresp(dresp1)
  );

  typedef struct {
    logic        is_rd;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem_model [int];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cycle = 0;
  int          obs_accepts = 0;
  int          obs_data_ok = 0;
  bit          m_busy = 1'b0;
  logic [15:0] m_lfsr = SEED;
  logic [31:0] last_rdata = 32'h0;

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  // Reference model: grant, latency and data for the main instance
  always @(negedge clk) begin : monitor
    bit          exp_ao;
    bit          exp_dok;
    bit          lfsr_ok;
    int          lat;
    int          idx;
    logic [31:0] w;
    exp_t        e;
    if (!resetn) begin
      check32("rst_addr_ok", 32'(dresp.addr_ok), 32'h0);
      check32("rst_data_ok", 32'(dresp.data_ok), 32'h0);
      check32("rst_data", dresp.data, 32'h0);
      sb.delete();
      m_busy = 1'b0;
      m_lfsr = SEED;
    end else begin
`ifdef DBUS_RESP_LFSR_STALL_EN
      lfsr_ok = m_lfsr[0];
      lat     = int'(LAT) + int'(m_lfsr[2:1]);
`else
      lfsr_ok = 1'b1;
      lat     = int'(LAT);
`endif
      exp_ao  = !m_busy && dreq.valid && lfsr_ok;
      exp_dok = (sb.size() > 0) && (sb[0].due == cycle);
      if (dresp.addr_ok) obs_accepts++;
      if (dresp.data_ok) obs_data_ok++;
      check32("addr_ok", 32'(dresp.addr_ok), 32'(exp_ao));
      check32("data_ok", 32'(dresp.data_ok), 32'(exp_dok));
      if (exp_dok) begin
        e = sb[0];
        if (e.is_rd) begin
          check32("rd_data", dresp.data, e.data);
          last_rdata = dresp.data;
        end else begin
          check32("wr_resp_data", dresp.data, 32'h0);
        end
        sb.pop_front();
        m_busy = 1'b0;
      end
      if (exp_ao) begin
        idx = int'(dreq.addr[AW+1:2]);
        w   = mem_model.exists(idx) ? mem_model[idx] : 32'h0;
        if (dreq.strobe == 4'h0) begin
          sb.push_back('{is_rd: 1'b1, data: w, due: cycle + lat});
        end else begin
          for (int i = 0; i < 4; i++) begin
            if (dreq.strobe[i]) w[8*i +: 8] = dreq.data[8*i +: 8];
          end
          mem_model[idx] = w;
          sb.push_back('{is_rd: 1'b0, data: 32'h0, due: cycle + lat});
        end
        m_busy = 1'b1;
      end
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
    cycle++;
  end

  task automatic wait_quiet();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sb.size() > 0 && n < 64);
    if (sb.size() > 0) check32("resp_timeout", 32'(sb.size()), 32'h0);
  endtask

  task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    @(posedge clk); #1;
    dreq.valid  = 1'b1;
    dreq.addr   = a;
    dreq.data   = d;
    dreq.strobe = s;
    dreq.size   = (s == 4'h1 || s == 4'h2 || s == 4'h4 || s == 4'h8) ? MSIZE1 :
                  (s == 4'h3 || s == 4'hC) ? MSIZE2 : MSIZE4;
    do begin
      @(negedge clk);
      n++;
    end while (!dresp.addr_ok && n < 64);
    if (!dresp.addr_ok) check32("grant_timeout", 32'h0, 32'h1);
    @(posedge clk); #1;
    dreq.valid = 1'b0;
    wait_quiet();
  endtask

  initial begin
    int a0;
    int d0;
    dreq  = '0;
    dreq1 = '0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    // Full word write/read, then byte and halfword lanes
    do_req(32'h10, 32'hDEADBEEF, 4'hF);
    do_req(32'h10, 32'h0, 4'h0);
    check32("sw_lw", last_rdata, 32'hDEADBEEF);
    do_req(32'h10, 32'h00AA0000, 4'h4);
    do_req(32'h10, 32'h0, 4'h0);
    check32("sb_lane2", last_rdata, 32'hDEAABEEF);
    do_req(32'h10, 32'h12340000, 4'hC);
    do_req(32'h10, 32'h0, 4'h0);
    check32("sh_upper", last_rdata, 32'h1234BEEF);

    // Address aliasing above the word-index field
    do_req(32'h1000, 32'h5A5AC3C3, 4'hF);
    do_req(32'h0000, 32'h0, 4'h0);
    check32("alias_1000", last_rdata, 32'h5A5AC3C3);
    do_req(32'hFFFFF012, 32'h0, 4'h0);
    check32("alias_high", last_rdata, 32'h1234BEEF);

    // Valid held through WAIT/RESP: one accept per request
    a0 = obs_accepts;
    @(posedge clk); #1;
    dreq.valid = 1'b1; dreq.addr = 32'h10; dreq.strobe = 4'h0; dreq.size = MSIZE4;
    repeat (7) @(negedge clk);
    @(posedge clk); #1;
    dreq.valid = 1'b0;
    wait_quiet();
`ifndef DBUS_RESP_LFSR_STALL_EN
    check32("busy_accepts", 32'(obs_accepts - a0), 32'd3);
`endif

    // Randomised traffic over a small pre-initialised window
    for (int i = 0; i < 8; i++) do_req(32'h100 + 32'(4 * i), $urandom, 4'hF);
    for (int i = 0; i < 24; i++)
      do_req(32'h100 + 32'(4 * $urandom_range(0, 7)), $urandom, 4'($urandom_range(0, 15)));

    // Reset while a read is in WAIT: abandoned, no late data_ok
    @(posedge clk); #1;
    dreq.valid = 1'b1; dreq.addr = 32'h10; dreq.strobe = 4'h0;
    d0 = 0;
    do begin
      @(negedge clk);
      d0++;
    end while (!dresp.addr_ok && d0 < 64);
    @(posedge clk); #1;
    dreq.valid = 1'b0;
    resetn = 1'b0;
    #1;
    check32("rst_async_addr_ok", 32'(dresp.addr_ok), 32'h0);
    check32("rst_async_data_ok", 32'(dresp.data_ok), 32'h0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    d0 = obs_data_ok;
    repeat (6) @(negedge clk);
    check32("no_data_ok_after_rst", 32'(obs_data_ok - d0), 32'h0);
    do_req(32'h10, 32'h0, 4'h0);
    check32("ram_kept_over_rst", last_rdata, 32'h1234BEEF);

`ifndef DBUS_RESP_LFSR_STALL_EN
    // LATENCY=1: write then back-to-back reads alternate addr_ok/data_ok
    @(posedge clk); #1;
    dreq1.valid = 1'b1; dreq1.addr = 32'h20; dreq1.size = MSIZE4;
    dreq1.strobe = 4'hF; dreq1.data = 32'hCAFEF00D;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check32("l1_addr_ok", 32'(dresp1.addr_ok), 32'((k % 2) == 0));
      check32("l1_data_ok", 32'(dresp1.data_ok), 32'((k % 2) == 1));
      if (k == 1) check32("l1_wr_data", dresp1.data, 32'h0);
      if (k > 1 && (k % 2) == 1) check32("l1_rd_data", dresp1.data, 32'hCAFEF00D);
      if (k == 1) begin
        @(posedge clk); #1;
        dreq1.strobe = 4'h0;
      end
    end
    @(posedge clk); #1;
    dreq1.valid = 1'b0;
`endif

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
